// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // The reserved encoding 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane merge and load lane extract/extend
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       addr_lo,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] mem_word,
    output logic [WIDTH-1:0] merged,
    output logic [WIDTH-1:0] load_data
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted   = mem_word >> {addr_lo, 3'b000};
        merged    = mem_word;
        load_data = mem_word;
        case (size)
            SZ_BYTE: begin
                merged[{addr_lo, 3'b000} +: 8] = store_data[7:0];
                load_data = is_unsigned ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                        : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                merged[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
                load_data = is_unsigned ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                        : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
                merged    = store_data;
                load_data = mem_word;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store initiator with sub-word read-modify-write; LSU_MISALIGN_TRAP_EN enables misalignment errors
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH  = lsu_pkg::WIDTH,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    lsu_state_e       state;
    logic             lat_we;
    logic [1:0]       lat_size;
    logic             lat_unsigned;
    logic [1:0]       lat_addr_lo;
    logic [WIDTH-1:0] lat_wdata;

    logic [1:0]       acc_size;
    logic [1:0]       acc_addr_lo;
    logic             acc_err;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] load_data;

    assign acc_size  = norm_size(req_size);
    assign req_ready = (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_addr_lo = req_addr[1:0];
    assign acc_err     = ((acc_size == SZ_HALF) && req_addr[0]) ||
                         ((acc_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    // Without the trap, misaligned requests are silently snapped to natural alignment.
    assign acc_addr_lo = (acc_size == SZ_WORD) ? 2'b00 :
                         (acc_size == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];
    assign acc_err     = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .size        (lat_size),
        .addr_lo     (lat_addr_lo),
        .is_unsigned (lat_unsigned),
        .store_data  (lat_wdata),
        .mem_word    (mem_rdata),
        .merged      (merged),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            lat_we       <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_addr_lo  <= 2'b00;
            lat_wdata    <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_size     <= acc_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr_lo  <= acc_addr_lo;
                        lat_wdata    <= req_wdata;
                        mem_addr     <= WIDTH'(req_addr >> 2);
                        resp_rdata   <= '0;
                        resp_err     <= 1'b0;
                        if (acc_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && (acc_size == SZ_WORD)) begin
                            state     <= ST_WRITE;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= ST_READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_we) begin
                        state     <= ST_WRITE;
                        mem_write <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed table, reset-abort sequence and randomized model check for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_unsigned;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        if (rst_n && req_valid && req_ready) n_acc++;
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL rw_exclusive mem_read=%0b mem_write=%0b required not both", mem_read, mem_write);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int nr, output int nw);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        rd = '0; er = 1'b0; lat = 0; nr = 0; nw = 0;
        n_txn++;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_read) nr++;
            if (mem_write) nw++;
            chk("ready_busy", {31'b0, req_ready}, 32'd0);
            if (resp_valid) begin
                lat = c;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        req_valid = 1'b0;
        if (lat == 0) begin
            errors++;
            $display("FAIL resp_timeout got=no_resp required=resp_valid");
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int lo, input int nb, input logic uns);
        logic [31:0] v;
        v = word >> (8 * lo);
        if (nb == 1) v = uns ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
        else if (nb == 2) v = uns ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    typedef struct {
        logic        pre;
        int          pidx;
        logic [31:0] pval;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
        int          enr;
        int          enw;
        int          cidx;
        logic [31:0] cval;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, nr, nw;

        vecs[0]  = '{1'b1, 92, 32'h0, 1'b1, SZ_WORD, 1'b0, 32'h170, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 92, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 0, 32'h0, 1'b0, SZ_WORD, 1'b0, 32'h170, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 92, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5, 32'h11223344, 1'b1, SZ_BYTE, 1'b0, 32'h16, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1, 1, 5, 32'h11AA3344};
        vecs[3]  = '{1'b1, 5, 32'h80FF7F01, 1'b0, SZ_BYTE, 1'b0, 32'h15, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0, 5, 32'h80FF7F01};
        vecs[4]  = '{1'b0, 0, 32'h0, 1'b0, SZ_BYTE, 1'b0, 32'h16, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1, 0, 5, 32'h80FF7F01};
        vecs[5]  = '{1'b0, 0, 32'h0, 1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, 32'h000080FF, 1'b0, 2, 1, 0, 5, 32'h80FF7F01};
        vecs[6]  = '{1'b0, 0, 32'h0, 1'b0, SZ_BYTE, 1'b1, 32'h17, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 5, 32'h80FF7F01};
        vecs[7]  = '{1'b0, 0, 32'h0, 1'b0, SZ_BYTE, 1'b0, 32'h17, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 5, 32'h80FF7F01};
        vecs[8]  = '{1'b0, 0, 32'h0, 1'b1, SZ_HALF, 1'b0, 32'h14, 32'hABCD1234, 32'h0, 1'b0, 3, 1, 1, 5, 32'h80FF1234};
        vecs[9]  = '{1'b0, 0, 32'h0, 1'b0, 2'b11, 1'b1, 32'h14, 32'h0, 32'h80FF1234, 1'b0, 2, 1, 0, 5, 32'h80FF1234};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{1'b1, 4, 32'hCAFE5A5A, 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0, 4, 32'hCAFE5A5A};
        vecs[11] = '{1'b1, 6, 32'h0BADF00D, 1'b1, SZ_WORD, 1'b0, 32'h1A, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 6, 32'h0BADF00D};
`else
        vecs[10] = '{1'b1, 4, 32'hCAFE5A5A, 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 1, 0, 4, 32'hCAFE5A5A};
        vecs[11] = '{1'b1, 6, 32'h0BADF00D, 1'b1, SZ_WORD, 1'b0, 32'h1A, 32'h12345678, 32'h0, 1'b0, 2, 0, 1, 6, 32'h12345678};
`endif
        vecs[12] = '{1'b0, 0, 32'h0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 1, 0, 4, 32'hCAFE5A5A};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].pre) mem[vecs[i].pidx] = vecs[i].pval;
            run_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, er, lat, nr, nw);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].erd);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].eerr});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
            chk($sformatf("v%0d_reads", i), nr, vecs[i].enr);
            chk($sformatf("v%0d_writes", i), nw, vecs[i].enw);
            chk($sformatf("v%0d_memword", i), mem[vecs[i].cidx], vecs[i].cval);
        end

        // Reset while the read half of a byte store is in flight.
        mem[5] = 32'h11223344;
        req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0; req_addr = 32'h16; req_wdata = 32'h000000AA;
        req_valid = 1'b1;
        n_txn++;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_read", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
        chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_mem_intact", mem[5], 32'h11223344);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int t = 0; t < 150; t++) begin
            logic        we, uns, eerr;
            logic [1:0]  sz;
            logic [31:0] addr, wd, erd, w;
            int          nb, a, elat, p;
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 255));
            wd   = $urandom;
            nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
            eerr = (int'(addr) % nb) != 0;
`else
            eerr = 1'b0;
`endif
            a    = int'(addr) - (int'(addr) % nb);
            erd  = 32'h0;
            if (eerr) begin
                elat = 1;
            end else if (!we) begin
                erd  = ref_load(ref_mem[a / 4], a % 4, nb, uns);
                elat = 2;
            end else begin
                w = ref_mem[a / 4];
                for (int b = 0; b < nb; b++) begin
                    p = (a % 4) + b;
                    w = (w & ~(32'hFF << (8 * p))) | (((wd >> (8 * b)) & 32'hFF) << (8 * p));
                end
                ref_mem[a / 4] = w;
                elat = (nb == 4) ? 2 : 3;
            end
            run_txn(we, sz, uns, addr, wd, rd, er, lat, nr, nw);
            chk($sformatf("rnd%0d_rdata", t), rd, erd);
            chk($sformatf("rnd%0d_err", t), {31'b0, er}, {31'b0, eerr});
            chk($sformatf("rnd%0d_latency", t), lat, elat);
        end
        for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
        chk("accept_count", n_acc, n_txn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator between the core's memory stage and the word-addressed data memory. Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. Drives the data memory's mem_read/mem_write/addr/write_data port, performing read-modify-write for sub-word stores. Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
WIDTH, 32, data and address width; only 32 is supported (4 byte lanes).
ADDR_W, 32, width of the byte address from the core.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  core request present.
req_ready  out  1  high in IDLE only.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
req_addr  in  ADDR_W  byte address.
req_wdata  in  WIDTH  store data, right-aligned.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned access, valid with resp_valid.
mem_read  out  1  to data memory.
mem_write  out  1  to data memory.
mem_addr  out  WIDTH  word index = latched req_addr >> 2.
mem_wdata  out  WIDTH  full word to write.
mem_rdata  in  WIDTH  combinational read data from memory.

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready 1; resp_valid, resp_err, mem_read, mem_write 0; resp_rdata, mem_addr, mem_wdata, all latches 0.
- FSM states IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid: latch we/size/unsigned/addr/wdata. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err. Else load -> READ; word store -> WRITE; byte/half store -> READ.
- READ: mem_read=1, mem_addr driven; capture mem_rdata at edge. Load -> RESP; store -> WRITE.
- WRITE: mem_write=1; mem_wdata = captured word with selected lane(s) replaced by req_wdata low byte/half (lane = addr[1:0], half lane = addr[1]); word store writes req_wdata unmerged. -> RESP.
- RESP: resp_valid=1 one cycle; resp_rdata = selected lane shifted down, extended per req_unsigned (word passes through); -> IDLE. mem_read/mem_write 0.
- Latency (accept edge = 0): word store and load resp_valid in cycle 2; sub-word store in cycle 3; misaligned in cycle 1. No back-to-back: next accept no earlier than the cycle after RESP.
- mem_read and mem_write never high together; neither asserted outside READ/WRITE.
- mem_addr/mem_wdata hold latched values outside access states (no glitch requirement, but stable during access).
- req_valid while not ready: ignored; core must hold request.
- Reset mid-operation: FSM aborts to IDLE immediately; a write in progress is not issued if rst_n falls before the WRITE clock edge.
- Lane wrap: byte at addr[1:0]=3 uses bits 31:24; no cross-word access exists.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned detection as above; resp_err=1, no memory access.
- Undefined: low address bits forced to natural alignment (half clears addr[0], word clears addr[1:0]); access proceeds normally; resp_err tied 0.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, WIDTH constant.
- One sub-module: lsu_lane_align (combinational store merge and load extract/extend), instanced once.

Test Plan:
- Word store addr 0x170, data 0xDEADBEEF; then word load 0x170 -> mem word 92 = 0xDEADBEEF, resp_rdata 0xDEADBEEF, resp_valid 2 cycles after accept.
- Mem word 5 = 0x11223344; byte store 0xAA to addr 0x16 -> word 5 = 0x11AA3344, resp_valid cycle 3, exactly one mem_read and one mem_write cycle.
- Mem word 5 = 0x80FF7F01; byte load 0x15 signed -> 0x0000007F; byte load 0x16 signed -> 0xFFFFFFFF; half load 0x16 unsigned -> 0x000080FF.
- Half load addr 0x13 with LSU_MISALIGN_TRAP_EN -> resp_err 1, resp_rdata 0, no mem_read, resp cycle 1; without macro -> loads half at 0x12, resp_err 0.
- Assert rst_n low in READ of a byte store -> no mem_write, outputs at reset values, req_ready 1 immediately.
- req_valid held high during busy states -> only one request accepted per transaction; req_ready 0 in READ/WRITE/RESP.
